// File: rtl/register_file_pkg.sv
// Shared types and constants for the multi-port register file.
package register_file_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set by reserve, cleared by write, reserve wins on a tie.
module rf_scoreboard
  import register_file_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 5,
  parameter int NUM_READ_PORTS = 2
) (
  input  logic                                          clock_in,
  input  logic                                          reset_n_in,
  input  logic                                          set_en,
  input  logic [ADDRESS_WIDTH-1:0]                      set_idx,
  input  logic                                          clear_en,
  input  logic [ADDRESS_WIDTH-1:0]                      clear_idx,
  input  logic [NUM_READ_PORTS-1:0][ADDRESS_WIDTH-1:0]  read_idx,
  output logic [NUM_READ_PORTS-1:0]                     busy_out
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;

  // Clear applied before set so a same-index reserve overrides the write.
  always_comb begin
    busy_next = busy;
    if (clear_en) busy_next[clear_idx] = 1'b0;
    if (set_en)   busy_next[set_idx]   = 1'b1;
    busy_next[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) busy <= '0;
    else             busy <= busy_next;
  end

  always_comb begin
    busy_out = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      busy_out[p] = busy[read_idx[p]];
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with post-reset clear sweep, busy scoreboard
// and optional write-to-read bypass.
module register_file_mp
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDRESS_WIDTH  = 5,
  parameter int NUM_READ_PORTS = 2,
  parameter int BYPASS         = 1
) (
  input  logic                                          clock_in,
  input  logic                                          reset_n_in,
  output logic                                          ready_out,
  input  logic                                          regWrite_in,
  input  logic [ADDRESS_WIDTH-1:0]                      write_register_in,
  input  logic [DATA_WIDTH-1:0]                         write_data_in,
  input  logic                                          reserve_in,
  input  logic [ADDRESS_WIDTH-1:0]                      reserve_register_in,
  input  logic [NUM_READ_PORTS-1:0][ADDRESS_WIDTH-1:0]  read_register_in,
  output logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]     read_data_out,
  output logic [NUM_READ_PORTS-1:0]                     read_busy_out,
  output rf_state_t                                     debug_state
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX  = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX  = ADDRESS_WIDTH'(ZERO_REG);

  rf_state_t                state, state_next;
  logic [ADDRESS_WIDTH-1:0] ptr, ptr_next;
  logic [DATA_WIDTH-1:0]    rf [DEPTH];

  logic                      ready;
  logic                      write_en;
  logic                      reserve_en;
  logic [NUM_READ_PORTS-1:0] busy_raw;

  assign ready       = (state == RF_READY);
  assign ready_out   = ready;
  assign debug_state = state;
  assign write_en    = ready && regWrite_in && (write_register_in != ZERO_IDX);
  assign reserve_en  = ready && reserve_in && (reserve_register_in != ZERO_IDX);

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state <= RF_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    if (state == RF_CLEAR) begin
      ptr_next = ptr + ADDRESS_WIDTH'(1);
      if (ptr == LAST_IDX) state_next = RF_READY;
    end
  end

  // Storage has no reset; the sweep is the only thing that zeroes it.
  always_ff @(posedge clock_in) begin
    if (state == RF_CLEAR)  rf[ptr] <= '0;
    else if (write_en)      rf[write_register_in] <= write_data_in;
  end

  rf_scoreboard #(
    .ADDRESS_WIDTH  (ADDRESS_WIDTH),
    .NUM_READ_PORTS (NUM_READ_PORTS)
  ) u_scoreboard (
    .clock_in   (clock_in),
    .reset_n_in (reset_n_in),
    .set_en     (reserve_en),
    .set_idx    (reserve_register_in),
    .clear_en   (write_en),
    .clear_idx  (write_register_in),
    .read_idx   (read_register_in),
    .busy_out   (busy_raw)
  );

  always_comb begin
    read_data_out = '0;
    read_busy_out = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      logic hit;
      logic nonzero;
      nonzero = (read_register_in[p] != ZERO_IDX);
      hit     = (BYPASS != 0) && write_en && (write_register_in == read_register_in[p]);
      if (ready && nonzero) begin
        read_data_out[p] = hit ? write_data_in : rf[read_register_in[p]];
        read_busy_out[p] = busy_raw[p] && !hit;
      end
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: reset sweep, table of read/write/reserve
// vectors, bypass on/off, and reset-abort sequences.
module tb_register_file_mp;
  import register_file_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             regw;
  logic [4:0]       waddr;
  logic [15:0]      wdata;
  logic             rsv;
  logic [4:0]       rsv_addr;
  logic [1:0][4:0]  raddr;
  logic [1:0][15:0] rdata1, rdata0;
  logic [1:0]       busy1, busy0;
  logic             ready1, ready0;
  rf_state_t        state1, state0;

  int tests  = 0;
  int failed = 0;

  register_file_mp #(.DATA_WIDTH(16), .ADDRESS_WIDTH(5), .NUM_READ_PORTS(2), .BYPASS(1)) dut_bp (
    .clock_in(clk), .reset_n_in(rst_n), .ready_out(ready1),
    .regWrite_in(regw), .write_register_in(waddr), .write_data_in(wdata),
    .reserve_in(rsv), .reserve_register_in(rsv_addr),
    .read_register_in(raddr), .read_data_out(rdata1), .read_busy_out(busy1),
    .debug_state(state1)
  );

  register_file_mp #(.DATA_WIDTH(16), .ADDRESS_WIDTH(5), .NUM_READ_PORTS(2), .BYPASS(0)) dut_nb (
    .clock_in(clk), .reset_n_in(rst_n), .ready_out(ready0),
    .regWrite_in(regw), .write_register_in(waddr), .write_data_in(wdata),
    .reserve_in(rsv), .reserve_register_in(rsv_addr),
    .read_register_in(raddr), .read_data_out(rdata0), .read_busy_out(busy0),
    .debug_state(state0)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    regw = 1'b0; waddr = '0; wdata = '0; rsv = 1'b0; rsv_addr = '0; raddr = '0;
  endtask

  // Releases reset at a negedge and checks ready rises exactly on edge 32.
  task automatic sweep_and_check(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      @(posedge clk);
      #1;
      check({tag, "_ready"}, {31'd0, ready1}, {31'd0, (e == 32)});
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [15:0] wd;
    logic        rs;
    logic [4:0]  ra;
    logic [4:0]  rp0;
    logic [4:0]  rp1;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        b0;
    logic        b1;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // write r5, r0 drop, reserve/write interplay on r3, reserve r0, top index
    vecs[0]  = '{1'b1, 5'd5,  16'hBEEF, 1'b0, 5'd0, 5'd5,  5'd5,  16'hBEEF, 16'hBEEF, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 5'd5,  5'd5,  16'hBEEF, 16'hBEEF, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 5'd0,  16'h1234, 1'b0, 5'd0, 5'd0,  5'd5,  16'h0000, 16'hBEEF, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 5'd0,  5'd0,  16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd3, 5'd3,  5'd5,  16'h0000, 16'hBEEF, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 5'd3,  5'd3,  16'h0000, 16'h0000, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 5'd3,  16'h1111, 1'b0, 5'd0, 5'd3,  5'd4,  16'h1111, 16'h0000, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 5'd3,  5'd3,  16'h1111, 16'h1111, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 5'd3,  16'h2222, 1'b1, 5'd3, 5'd3,  5'd3,  16'h2222, 16'h2222, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 5'd3,  5'd3,  16'h2222, 16'h2222, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd0, 5'd0,  5'd3,  16'h0000, 16'h2222, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 5'd0,  5'd0,  16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd3, 5'd3,  5'd3,  16'h2222, 16'h2222, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 5'd3,  5'd3,  16'h2222, 16'h2222, 1'b1, 1'b1};
    vecs[14] = '{1'b1, 5'd31, 16'hFFFF, 1'b0, 5'd0, 5'd31, 5'd30, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 5'd31, 5'd31, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};

    idle();
    rst_n = 1'b0;
    #12;
    check("rst_ready", {31'd0, ready1}, 32'd0);
    check("rst_data", {rdata1[1], rdata1[0]}, 32'd0);
    check("rst_busy", {30'd0, busy1}, 32'd0);

    // Test 1: sweep timing, then every register reads zero on both ports
    sweep_and_check("sweep1");
    check("state_ready", {31'd0, state1 == RF_READY}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      raddr[0] = 5'(i);
      raddr[1] = 5'(31 - i);
      #1;
      check("zero_p0", {16'd0, rdata1[0]}, 32'd0);
      check("zero_p1", {16'd0, rdata1[1]}, 32'd0);
      check("zero_nb", {rdata0[1], rdata0[0]}, 32'd0);
    end

    // Tests 2 and 4: table of same-cycle views before each commit edge
    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      regw = vecs[v].we; waddr = vecs[v].wa; wdata = vecs[v].wd;
      rsv = vecs[v].rs; rsv_addr = vecs[v].ra;
      raddr[0] = vecs[v].rp0; raddr[1] = vecs[v].rp1;
      #1;
      check($sformatf("vec%0d_d0", v), {16'd0, rdata1[0]}, {16'd0, vecs[v].d0});
      check($sformatf("vec%0d_d1", v), {16'd0, rdata1[1]}, {16'd0, vecs[v].d1});
      check($sformatf("vec%0d_b0", v), {31'd0, busy1[0]}, {31'd0, vecs[v].b0});
      check($sformatf("vec%0d_b1", v), {31'd0, busy1[1]}, {31'd0, vecs[v].b1});
    end

    // Test 3: bypass on versus off
    @(negedge clk);
    idle();
    regw = 1'b1; waddr = 5'd7; wdata = 16'h00A5;
    raddr[0] = 5'd5; raddr[1] = 5'd7;
    #1;
    check("bp_on_p1", {16'd0, rdata1[1]}, 32'h00A5);
    check("bp_off_p1", {16'd0, rdata0[1]}, 32'h0000);
    check("bp_off_p0", {16'd0, rdata0[0]}, 32'hBEEF);
    @(negedge clk);
    regw = 1'b0;
    #1;
    check("bp_off_after", {16'd0, rdata0[1]}, 32'h00A5);
    check("bp_on_after", {16'd0, rdata1[1]}, 32'h00A5);

    // Test 6 setup: r9 written and reserved together, so it ends up busy
    @(negedge clk);
    idle();
    regw = 1'b1; waddr = 5'd9; wdata = 16'h9999; rsv = 1'b1; rsv_addr = 5'd9;
    @(negedge clk);
    idle();
    raddr[0] = 5'd9; raddr[1] = 5'd9;
    #1;
    check("r9_data", {16'd0, rdata1[0]}, 32'h9999);
    check("r9_busy", {31'd0, busy1[1]}, 32'd1);
    check("r9_busy_nb", {31'd0, busy0[0]}, 32'd1);

    // Test 5: reset, then abort the sweep at index 10 while writes/reserves hammer r9
    rst_n = 1'b0;
    #1;
    check("abort_ready", {31'd0, ready1}, 32'd0);
    check("abort_busy", {30'd0, busy1}, 32'd0);
    check("abort_data", {rdata1[1], rdata1[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    regw = 1'b1; waddr = 5'd9; wdata = 16'h5A5A; rsv = 1'b1; rsv_addr = 5'd9;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      check("mid_ready", {31'd0, ready1}, 32'd0);
      check("mid_out", {14'd0, busy1, rdata1[0]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    rst_n = 1'b0;
    sweep_and_check("sweep2");

    // Test 6: r9 cleared and idle after the re-sweep; clear-time traffic was dropped
    @(negedge clk);
    idle();
    raddr[0] = 5'd9; raddr[1] = 5'd5;
    #1;
    check("r9_after_data", {16'd0, rdata1[0]}, 32'd0);
    check("r9_after_busy", {31'd0, busy1[0]}, 32'd0);
    check("r5_after_data", {16'd0, rdata1[1]}, 32'd0);
    check("r9_after_nb", {16'd0, rdata0[0]}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
